// File: rtl/comparador_serial_izq_der_if.sv
// Handshake and data bundle for the bit-serial MSB-first comparator.
// The master drives start/A/B; the slave returns status and result.
interface comparador_serial_izq_der_if #(
    parameter int N = 8
) ();
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [1:0]   estado;
    logic         mayor;
    logic         menor;
    logic         igual;

    modport master (
        output start, A, B,
        input  busy, done, estado, mayor, menor, igual
    );

    modport slave (
        input  start, A, B,
        output busy, done, estado, mayor, menor, igual
    );
endinterface

// File: rtl/comparador_serial_izq_der.sv
// Bit-serial magnitude comparator, one iterative cell scanned MSB to LSB.
// COMPARADOR_EARLY_EXIT_EN: finish on the first differing bit pair.
module comparador_serial_izq_der #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    comparador_serial_izq_der_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [N-1:0]  r_shA;
    logic [N-1:0]  r_shB;
    logic [1:0]    r_estado;
    logic [CW-1:0] r_cnt;
    logic          r_mayor;
    logic          r_menor;
    logic          r_igual;
    logic [1:0]    w_cell;
    logic          w_last;
    logic          w_busy;
    logic          w_done;

    // Cell: b/c are absorbing; a (and illegal 00) decided by the bit pair.
    function automatic logic [1:0] cell_next(
        input logic [1:0] st,
        input logic       ai,
        input logic       bi
    );
        logic [1:0] nx;
        if (st == 2'b10 || st == 2'b11) begin
            nx = st;
        end else if (ai == bi) begin
            nx = 2'b01;
        end else if (ai) begin
            nx = 2'b10;
        end else begin
            nx = 2'b11;
        end
        return nx;
    endfunction

    assign w_cell = cell_next(r_estado, r_shA[N-1], r_shB[N-1]);

`ifdef COMPARADOR_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) || w_cell[1];
`else
    assign w_last = (r_cnt == '0);
`endif

    always_comb begin
        w_state_nx = r_state;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_done     = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shA    <= '0;
            r_shB    <= '0;
            r_estado <= 2'b01;
            r_cnt    <= '0;
            r_mayor  <= 1'b0;
            r_menor  <= 1'b0;
            r_igual  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shA    <= bus.A;
                        r_shB    <= bus.B;
                        r_estado <= 2'b01;
                        r_cnt    <= CW'(N - 1);
                        r_mayor  <= 1'b0;
                        r_menor  <= 1'b0;
                        r_igual  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_estado <= w_cell;
                    r_shA    <= {r_shA[N-2:0], 1'b0};
                    r_shB    <= {r_shB[N-2:0], 1'b0};
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_mayor <= (w_cell == 2'b10);
                        r_menor <= (w_cell == 2'b11);
                        r_igual <= ~w_cell[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.estado = r_estado;
    assign bus.mayor  = r_mayor;
    assign bus.menor  = r_menor;
    assign bus.igual  = r_igual;

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Self-checking bench: directed table, corner sequences, random words
// checked against an arithmetic model of the serial comparison.
module tb_comparador_serial_izq_der;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    comparador_serial_izq_der_if #(.N(N)) bus ();

    comparador_serial_izq_der #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         mayor;
        logic         menor;
        logic         igual;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cell state after j bits: compare the top j bits as integers.
    function automatic int exp_estado(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input int           j
    );
        int ta;
        int tb;
        ta = int'(a) >> (N - j);
        tb = int'(b) >> (N - j);
        if (ta > tb) return 2;
        if (ta < tb) return 3;
        return 1;
    endfunction

    function automatic int exp_lat(
        input logic [N-1:0] a,
        input logic [N-1:0] b
    );
`ifdef COMPARADOR_EARLY_EXIT_EN
        int d;
        d = int'(a ^ b);
        if (d == 0) return N;
        return N - $clog2(d + 1) + 1;
`else
        return N;
`endif
    endfunction

    task automatic run_cmp(
        input  logic [N-1:0] a,
        input  logic [N-1:0] b,
        input  int           restart_at,
        input  string        tag,
        output logic         om,
        output logic         ol,
        output logic         oi
    );
        int k;
        int e;
        bit seen;
        k = exp_lat(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = N'($urandom);
        bus.B     = N'($urandom);
        chk({tag, ".busy_start"}, int'(bus.busy), 1);
        chk({tag, ".res_clear"},
            int'({bus.mayor, bus.menor, bus.igual}), 0);
        chk({tag, ".estado_start"}, int'(bus.estado), 1);
        e    = 0;
        seen = 1'b0;
        while (!seen && e < N + 2) begin
            @(posedge clk);
            #1;
            e++;
            bus.start = 1'b0;
            if (e == restart_at) begin
                bus.start = 1'b1;
                bus.A     = '1;
                bus.B     = '0;
            end
            seen = bus.done;
            if (!seen) begin
                chk({tag, ".busy"}, int'(bus.busy), 1);
                chk({tag, ".estado"}, int'(bus.estado),
                    exp_estado(a, b, e));
            end
        end
        bus.start = 1'b0;
        chk({tag, ".done_seen"}, int'(seen), 1);
        chk({tag, ".latency"}, e, k);
        chk({tag, ".busy_done"}, int'(bus.busy), 0);
        chk({tag, ".estado_end"}, int'(bus.estado),
            exp_estado(a, b, k));
        chk({tag, ".mayor"}, int'(bus.mayor), int'(a > b));
        chk({tag, ".menor"}, int'(bus.menor), int'(a < b));
        chk({tag, ".igual"}, int'(bus.igual), int'(a == b));
        om = bus.mayor;
        ol = bus.menor;
        oi = bus.igual;
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, int'(bus.done), 0);
        chk({tag, ".busy_idle"}, int'(bus.busy), 0);
    endtask

    vec_t vecs[$];

    initial begin
        logic         m;
        logic         l;
        logic         i;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        bit           seen;
        n_chk = 0;
        n_err = 0;

        vecs.push_back('{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h12, 8'h13, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h04, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1});

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.estado", int'(bus.estado), 1);
        chk("rst.res",
            int'({bus.mayor, bus.menor, bus.igual}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            run_cmp(vecs[v].a, vecs[v].b, -1, $sformatf("vec%0d", v),
                    m, l, i);
            chk($sformatf("vec%0d.tbl", v), int'({m, l, i}),
                int'({vecs[v].mayor, vecs[v].menor, vecs[v].igual}));
        end

        // Second start while busy must be ignored.
        run_cmp(8'h01, 8'h02, 2, "restart", m, l, i);
        chk("restart.menor", int'({m, l, i}), 3'b010);
        repeat (N + 2) begin
            @(posedge clk);
            #1;
            chk("restart.no_done", int'(bus.done), 0);
        end

        // Start asserted only during DONE must not launch a comparison.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h55;
        bus.B     = 8'h55;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen      = 1'b0;
        for (int c = 0; c < N + 2 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = bus.done;
        end
        chk("dnstart.seen", int'(seen), 1);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("dnstart.busy1", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("dnstart.busy2", int'(bus.busy), 0);

        // Reset in the middle of a comparison aborts it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'hF0;
        bus.B     = 8'h0F;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", int'(bus.busy), 0);
        chk("abort.done", int'(bus.done), 0);
        chk("abort.estado", int'(bus.estado), 1);
        chk("abort.res",
            int'({bus.mayor, bus.menor, bus.igual}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (N + 2) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("abort.no_done", int'(seen), 0);
        run_cmp(8'h0F, 8'hF0, -1, "post_rst", m, l, i);
        chk("post_rst.menor", int'({m, l, i}), 3'b010);

        for (int r = 0; r < 40; r++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
            if (r % 5 == 1) rb = ra ^ N'(1 << $urandom_range(0, N - 1));
            run_cmp(ra, rb, -1, $sformatf("rnd%0d", r), m, l, i);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
